mod107_seq_reducer: RTL

Sequential controller that reduces a wide operand (default 400 bits) modulo 107 by streaming it MSB-first in 6-bit chunks through one shared chunk-reduction step, using Horner accumulation: acc = (acc·64 + chunk) mod 107. It replaces a fully parallel bank of per-chunk residue LUTs plus an adder tree. It trades latency (one cycle per chunk) for area. It sits between the operand register file and the mod-107 result consumers, and uses a start/done handshake.

---
 rtl/mod107_seq_reducer.sv | 111 +++++++++++
 1 files changed

// File: rtl/mod107_seq_reducer.sv
// Streams a wide operand MSB-first in 6-bit chunks through one Horner step to get x mod 107.
// Optional abort input and logic are enabled by defining MOD107_SEQ_ABORT_EN.
module mod107_seq_reducer #(
  parameter int X_W = 400
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x,
`ifdef MOD107_SEQ_ABORT_EN
  input  logic           abort,
`endif
  output logic           busy,
  output logic           done,
  output logic [6:0]     residue
);

  localparam int N_CHUNKS = (X_W + 5) / 6;
  localparam int PAD_W    = N_CHUNKS * 6;
  localparam int CNT_W    = $clog2(N_CHUNKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [PAD_W-1:0]   sr_reg, sr_next;
  logic [6:0]         acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [6:0]         residue_reg, residue_next;

  // acc*64 + chunk is just a concatenation because the chunk is below 64.
  // The quotient is at most 63, so six restoring-subtract stages of 107*2^k give the exact remainder.
  logic [12:0] rem_stage [0:6];
  logic [6:0]  step_mod;

  assign rem_stage[0] = {acc_reg, sr_reg[PAD_W-1 -: 6]};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_sub
      localparam int K_INT = 107 << (5 - gi);
      assign rem_stage[gi+1] = (rem_stage[gi] >= 13'(K_INT)) ?
                               (rem_stage[gi] - 13'(K_INT)) : rem_stage[gi];
    end
  endgenerate

  assign step_mod = rem_stage[6][6:0];

  always_comb begin
    state_next   = state_reg;
    sr_next      = sr_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    residue_next = residue_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          sr_next          = '0;
          sr_next[X_W-1:0] = x;
          acc_next         = '0;
          cnt_next         = '0;
          state_next       = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
`ifdef MOD107_SEQ_ABORT_EN
        if (abort) begin
          acc_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else
`endif
        begin
          acc_next = step_mod;
          sr_next  = sr_reg << 6;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N_CHUNKS - 1)) begin
            residue_next = step_mod;
            state_next   = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sr_reg      <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      residue_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sr_reg      <= sr_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      residue_reg <= residue_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign residue = residue_reg;

endmodule
